// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered full adder family.
package full_adder_pkg;

    // Widest operand a single instance may be built with.
    localparam int MAX_WIDTH = 64;

    // Result layout at the widest legal size; instances use the same
    // {cout, s} ordering at their own width so the vector reads as {Cout, S}.
    typedef struct packed {
        logic                 cout;
        logic [MAX_WIDTH-1:0] s;
    } result_max_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for full_adder_reg.
interface full_adder_reg_if #(
    parameter int WIDTH = 1
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    // Producer of operands, consumer of results.
    modport master (
        output in_valid, A, B, Cin,
        input  S, Cout, out_valid
    );

    // The adder itself.
    modport slave (
        input  in_valid, A, B, Cin,
        output S, Cout, out_valid
    );

endinterface : full_adder_reg_if

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full adder cell.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry equations.
    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule : full_adder_bit

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {Cout, S} = A + B + Cin, one cycle latency.
module full_adder_reg
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    full_adder_reg_if.slave  bus
);

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] s;
    } result_t;

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("full_adder_reg: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    result_t          res_d;
    result_t          res_q;
    logic             valid_q;

    assign carry[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Assemble the combinational result from the end of the ripple chain.
    always_comb begin
        res_d      = '0;
        res_d.s    = sum;
        res_d.cout = carry[WIDTH];
    end

    // Output stage: result loads only on valid capture, valid pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.S         = res_q.s;
    assign bus.Cout      = res_q.cout;
    assign bus.out_valid = valid_q;

endmodule : full_adder_reg

// File: tb/tb_full_adder_reg.sv
// Self-checking bench for full_adder_reg at WIDTH 1, 4 and 8.
module tb_full_adder_reg;

    logic clk;
    logic rst_n;

    int unsigned total;
    int unsigned passed;

    full_adder_reg_if #(.WIDTH(1)) if1 ();
    full_adder_reg_if #(.WIDTH(4)) if4 ();
    full_adder_reg_if #(.WIDTH(8)) if8 ();

    full_adder_reg #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder_reg #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    full_adder_reg #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {Cout,S} for {A,B,Cin} = 0..7 on a 1-bit adder.
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    logic [8:0] mdl_res;
    logic       mdl_v;
    logic [2:0] v;

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        if1.in_valid = 1'b0; if1.A = '0; if1.B = '0; if1.Cin = 1'b0;
        if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.Cin = 1'b0;
        if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.Cin = 1'b0;

        #1;
        check("reset_w1", {if1.out_valid, if1.Cout, if1.S}, 0);
        check("reset_w4", {if4.out_valid, if4.Cout, if4.S}, 0);
        check("reset_w8", {if8.out_valid, if8.Cout, if8.S}, 0);
        step();
        step();
        #3 rst_n = 1'b1;

        // WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            if1.in_valid = 1'b1;
            {if1.A, if1.B, if1.Cin} = v;
            step();
            check($sformatf("tt%0d_res", i), {if1.Cout, if1.S}, tt[i]);
            check($sformatf("tt%0d_vld", i), if1.out_valid, 1);
        end
        if1.in_valid = 1'b0;
        step();
        check("tt_vld_drop", if1.out_valid, 0);

        // WIDTH=4 carry propagation and all-ones
        if4.in_valid = 1'b1; if4.A = 4'hF; if4.B = 4'h0; if4.Cin = 1'b1;
        step();
        check("w4_prop", {if4.out_valid, if4.Cout, if4.S}, {1'b1, 1'b1, 4'h0});
        if4.A = 4'hF; if4.B = 4'hF; if4.Cin = 1'b1;
        step();
        check("w4_ones", {if4.out_valid, if4.Cout, if4.S}, {1'b1, 1'b1, 4'hF});
        if4.in_valid = 1'b0;

        // Hold with changing inputs
        if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1; if1.Cin = 1'b0;
        step();
        check("hold_cap", {if1.out_valid, if1.Cout, if1.S}, 3'b110);
        if1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {if1.A, if1.B, if1.Cin} = 3'(i + 3);
            step();
            check($sformatf("hold%0d", i), {if1.out_valid, if1.Cout, if1.S}, 3'b010);
        end

        // Capture S=1, then reset asserted between edges before the pulse ends
        if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b0; if1.Cin = 1'b0;
        step();
        check("pre_rst", {if1.out_valid, if1.Cout, if1.S}, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {if1.out_valid, if1.Cout, if1.S}, 0);
        if1.A = 1'b1; if1.B = 1'b1; if1.Cin = 1'b1;
        step();
        check("rst_hold_a", {if1.out_valid, if1.Cout, if1.S}, 0);
        step();
        check("rst_hold_b", {if1.out_valid, if1.Cout, if1.S}, 0);
        if1.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        check("no_pulse", {if1.out_valid, if1.Cout, if1.S}, 0);
        if1.in_valid = 1'b1; if1.A = 1'b0; if1.B = 1'b1; if1.Cin = 1'b1;
        step();
        check("post_rst", {if1.out_valid, if1.Cout, if1.S}, 3'b110);
        if1.in_valid = 1'b0;

        // WIDTH=8 boundaries
        if8.in_valid = 1'b1; if8.A = 8'hFF; if8.B = 8'hFF; if8.Cin = 1'b1;
        step();
        check("w8_ones", {if8.out_valid, if8.Cout, if8.S}, {1'b1, 1'b1, 8'hFF});
        if8.A = 8'h00; if8.B = 8'h00; if8.Cin = 1'b0;
        step();
        check("w8_zero", {if8.out_valid, if8.Cout, if8.S}, {1'b1, 1'b0, 8'h00});
        if8.A = 8'hFF; if8.B = 8'h00; if8.Cin = 1'b1;
        step();
        check("w8_prop", {if8.out_valid, if8.Cout, if8.S}, {1'b1, 1'b1, 8'h00});

        // WIDTH=8 random, valid-gated; model holds the last accepted sum
        mdl_res = 9'h100;
        for (int i = 0; i < 1000; i++) begin
            if8.in_valid = ($urandom_range(0, 3) != 0);
            if8.A   = 8'($urandom);
            if8.B   = 8'($urandom);
            if8.Cin = 1'($urandom);
            mdl_v = if8.in_valid;
            if (if8.in_valid) mdl_res = 9'(if8.A) + 9'(if8.B) + 9'(if8.Cin);
            step();
            check("rnd_vld", if8.out_valid, mdl_v);
            check("rnd_res", {if8.Cout, if8.S}, mdl_res);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_full_adder_reg
